// File: rtl/apb_rf_pkg.sv
// Shared types and default constants for the APB register-file controller.
package apb_rf_pkg;
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int DefNumWords   = 64;
  localparam int DefAddrWidth  = 8;
  localparam int DefWaitStates = 1;
  localparam int CntWidth      = 4;
endpackage

// File: rtl/apb_rf_wait_cnt.sv
// Wait-state counter: loads on transfer setup, counts down during access, flags zero.
module apb_rf_wait_cnt
  import apb_rf_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [CntWidth-1:0] load_val,
  input  logic                dec,
  output logic                zero
);

  logic [CntWidth-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/apb_regfile_ctrl.sv
// APB slave front-end for an external 8-bit register file with configurable wait states.
// Optional macro APB_RF_ADDR_ERR_EN: out-of-range addresses answer with pslverr instead of aliasing.
module apb_regfile_ctrl
  import apb_rf_pkg::*;
#(
  parameter int NumWords   = DefNumWords,
  parameter int AddrWidth  = DefAddrWidth,
  parameter int WaitStates = DefWaitStates
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [AddrWidth-1:0] paddr,
  input  logic [7:0]           pwdata,
  output logic [7:0]           prdata,
  output logic                 pready,
  output logic                 pslverr,
  output logic                 rf_w_en,
  output logic [((NumWords > 1) ? $clog2(NumWords) : 1)-1:0] rf_offset,
  output logic [7:0]           rf_data_in,
  input  logic [7:0]           rf_data_out
);

  localparam int OffW = (NumWords > 1) ? $clog2(NumWords) : 1;

  state_t               state;
  logic [AddrWidth-1:0] addr_q;
  logic [7:0]           wdata_q;
  logic                 write_q;
  logic                 setup;
  logic                 cnt_zero;
  logic                 complete;
  logic                 addr_err;

  // A setup phase is only recognised from IDLE; a lone penable there is ignored.
  assign setup = (state == IDLE) && psel && !penable;

  apb_rf_wait_cnt u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (setup),
    .load_val (CntWidth'(WaitStates)),
    .dec      ((state == ACCESS) && psel),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            addr_q  <= paddr;
            wdata_q <= pwdata;
            write_q <= pwrite;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (!psel || cnt_zero) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef APB_RF_ADDR_ERR_EN
  assign addr_err = ({1'b0, addr_q} >= (AddrWidth + 1)'(NumWords));
`else
  logic unused_addr;
  assign unused_addr = ^addr_q;
  assign addr_err    = 1'b0;
`endif

  // Outputs are gated by reset so they read zero even while state is still being cleared.
  assign complete   = !reset && (state == ACCESS) && cnt_zero && psel && penable;
  assign pready     = complete;
  assign pslverr    = complete && addr_err;
  assign rf_w_en    = complete && write_q && !addr_err;
  assign prdata     = (complete && !write_q && !addr_err) ? rf_data_out : 8'h00;
  assign rf_offset  = reset ? '0 : addr_q[OffW-1:0];
  assign rf_data_in = reset ? 8'h00 : wdata_q;

endmodule
